// File: rtl/mdu_sequencer_if.sv
// EX-stage <-> MDU sequencer request/status bundle.
// The EX side (master) drives the request and operands; the sequencer (slave)
// returns stall, datapath strobes and status.
interface mdu_sequencer_if #(
  parameter int unsigned XLEN = 64
);

  logic            MduReqE;
  logic [2:0]      MduOpE;
  logic            MduWordE;
  logic [XLEN-1:0] SrcAE;
  logic [XLEN-1:0] SrcBE;
  logic            KillE;

  logic            MduStall;
  logic            MduLoad;
  logic            MduStep;
  logic            MduDone;
  logic [1:0]      MduSpecial;
  logic            MduBusy;
  logic [6:0]      StepCnt;

  modport master (
    output MduReqE, MduOpE, MduWordE, SrcAE, SrcBE, KillE,
    input  MduStall, MduLoad, MduStep, MduDone, MduSpecial, MduBusy, StepCnt
  );

  modport slave (
    input  MduReqE, MduOpE, MduWordE, SrcAE, SrcBE, KillE,
    output MduStall, MduLoad, MduStep, MduDone, MduSpecial, MduBusy, StepCnt
  );

endinterface

// File: rtl/mdu_sequencer.sv
// Cycle-level controller for the iterative multiply/divide unit.
// Accepts an M-extension op from EX, issues load/step/done strobes to the MDU
// datapath, short-circuits divide-by-zero and signed overflow, and holds the
// pipeline stall until the result is ready.
module mdu_sequencer #(
  parameter int unsigned XLEN       = 64,
  parameter int unsigned MUL_CYCLES = 3
) (
  input  logic         clk,
  input  logic         reset,
  mdu_sequencer_if.slave mdu
);

  localparam int unsigned CNT_W      = 7;
  localparam int unsigned DIV_STEPS  = 64;
  localparam int unsigned DIVW_STEPS = 32;

  localparam logic [1:0] SPEC_NONE = 2'b00;
  localparam logic [1:0] SPEC_DIVZ = 2'b01;
  localparam logic [1:0] SPEC_OVF  = 2'b10;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_BUSY = 2'b01,
    S_DONE = 2'b10
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_step_cnt;
  logic [CNT_W-1:0] w_step_cnt_nxt;
  logic [1:0]       r_special;
  logic [1:0]       w_special_nxt;

  logic             w_load;
  logic             w_step;
  logic             w_done;
  logic             w_stall;

  logic             w_is_div;
  logic             w_is_signed;
  logic             w_divz;
  logic             w_ovf;
  logic [1:0]       w_special_cls;
  logic [CNT_W-1:0] w_steps;

  // Operand classification: zero divisor and most-negative / -1 overflow,
  // evaluated at the operand width selected by the W variant.
  always_comb begin
    w_is_div    = mdu.MduOpE[2];
    w_is_signed = ~mdu.MduOpE[0];
    if (mdu.MduWordE) begin
      w_divz = (mdu.SrcBE[31:0] == 32'h0000_0000);
      w_ovf  = (mdu.SrcAE[31:0] == 32'h8000_0000) &&
               (mdu.SrcBE[31:0] == 32'hFFFF_FFFF);
    end else begin
      w_divz = (mdu.SrcBE == {XLEN{1'b0}});
      w_ovf  = (mdu.SrcAE == {1'b1, {(XLEN-1){1'b0}}}) &&
               (mdu.SrcBE == {XLEN{1'b1}});
    end

    w_special_cls = SPEC_NONE;
    if (w_is_div) begin
      if (w_divz) begin
        w_special_cls = SPEC_DIVZ;
      end else if (w_ovf && w_is_signed) begin
        w_special_cls = SPEC_OVF;
      end
    end

    if (!w_is_div) begin
      w_steps = CNT_W'(MUL_CYCLES);
    end else if (mdu.MduWordE) begin
      w_steps = CNT_W'(DIVW_STEPS);
    end else begin
      w_steps = CNT_W'(DIV_STEPS);
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state, strobes, stall and counter/special next values.
  always_comb begin
    w_state_nxt    = r_state;
    w_step_cnt_nxt = r_step_cnt;
    w_special_nxt  = r_special;
    w_load         = 1'b0;
    w_step         = 1'b0;
    w_done         = 1'b0;
    w_stall        = 1'b0;

    unique case (r_state)
      S_IDLE: begin
        if (mdu.MduReqE && !mdu.KillE) begin
          w_load  = 1'b1;
          w_stall = 1'b1;
          if (w_special_cls != SPEC_NONE) begin
            w_special_nxt  = w_special_cls;
            w_step_cnt_nxt = '0;
            w_state_nxt    = S_DONE;
          end else begin
            w_special_nxt  = SPEC_NONE;
            w_step_cnt_nxt = w_steps;
            w_state_nxt    = S_BUSY;
          end
        end
      end

      S_BUSY: begin
        if (mdu.KillE) begin
          w_step_cnt_nxt = '0;
          w_state_nxt    = S_IDLE;
        end else begin
          w_step         = 1'b1;
          w_stall        = 1'b1;
          w_step_cnt_nxt = r_step_cnt - CNT_W'(1);
          // Guard against a zero count so the counter can never wrap.
          if (r_step_cnt <= CNT_W'(1)) begin
            w_step_cnt_nxt = '0;
            w_state_nxt    = S_DONE;
          end
        end
      end

      S_DONE: begin
        w_state_nxt = S_IDLE;
        if (mdu.KillE) begin
          w_step_cnt_nxt = '0;
        end else begin
          w_done = 1'b1;
        end
      end

      default: begin
        w_step_cnt_nxt = '0;
        w_state_nxt    = S_IDLE;
      end
    endcase
  end

  // Step counter and latched special-case code.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_step_cnt <= '0;
      r_special  <= SPEC_NONE;
    end else begin
      r_step_cnt <= w_step_cnt_nxt;
      r_special  <= w_special_nxt;
    end
  end

  // Strobes and stall are combinational so they land in the request cycle;
  // reset masks them so nothing fires while the block is being cleared.
  assign mdu.MduLoad    = w_load  & ~reset;
  assign mdu.MduStep    = w_step  & ~reset;
  assign mdu.MduDone    = w_done  & ~reset;
  assign mdu.MduStall   = w_stall & ~reset;
  assign mdu.MduSpecial = r_special;
  assign mdu.MduBusy    = (r_state != S_IDLE);
  assign mdu.StepCnt    = r_step_cnt;

endmodule

// File: tb/tb_mdu_sequencer.sv
// Scoreboard bench for mdu_sequencer: stimulus pushes the expected completion
// (latency, special code, step count); a negedge monitor pops on MduDone.
module tb_mdu_sequencer;

  logic clk;
  logic reset;
  int   cyc;
  int   n_tests;
  int   n_fail;

  typedef struct {
    int         lat;
    logic [1:0] sp;
    int         steps;
  } exp_t;

  exp_t q[$];

  int load_cyc;
  int step_seen;

  mdu_sequencer_if #(.XLEN(64)) bus ();

  mdu_sequencer #(
    .XLEN       (64),
    .MUL_CYCLES (3)
  ) u_dut (
    .clk   (clk),
    .reset (reset),
    .mdu   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: strobe exclusivity, step counting, and completion checking.
  always @(negedge clk) begin
    if (reset) begin
      step_seen = 0;
    end else begin
      if ((32'(bus.MduLoad) + 32'(bus.MduStep) + 32'(bus.MduDone)) > 1) begin
        n_tests++;
        n_fail++;
        $display("FAIL strobe_onehot: load=%0b step=%0b done=%0b required at most one",
                 bus.MduLoad, bus.MduStep, bus.MduDone);
      end
      if (bus.MduLoad) begin
        load_cyc  = cyc;
        step_seen = 0;
      end
      if (bus.MduStep) step_seen++;
      if (bus.MduDone) begin
        if (q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_done: got MduDone=1 required 0 (cycle %0d)", cyc);
        end else begin
          exp_t e;
          e = q.pop_front();
          chk("done_latency", 64'(cyc - load_cyc), 64'(e.lat));
          chk("done_special", 64'(bus.MduSpecial), 64'(e.sp));
          chk("done_steps",   64'(step_seen),      64'(e.steps));
        end
      end
    end
  end

  task automatic drive(input logic [2:0] op, input logic w, input logic [63:0] a, input logic [63:0] b);
    bus.MduReqE  = 1'b1;
    bus.MduOpE   = op;
    bus.MduWordE = w;
    bus.SrcAE    = a;
    bus.SrcBE    = b;
  endtask

  // Issue one op (caller sits just after a rising edge) and wait for its Done.
  task automatic run_op(input string name, input logic [2:0] op, input logic w,
                        input logic [63:0] a, input logic [63:0] b,
                        input int lat, input logic [1:0] sp, input int steps,
                        output int done_cyc);
    exp_t e;
    e.lat = lat; e.sp = sp; e.steps = steps;
    drive(op, w, a, b);
    q.push_back(e);
    @(negedge clk);
    chk({name, "_load"},  64'(bus.MduLoad),  64'(1));
    chk({name, "_stall"}, 64'(bus.MduStall), 64'(1));
    done_cyc = -1;
    for (int i = 0; i < 200; i++) begin
      if (bus.MduDone) begin
        done_cyc = cyc;
        break;
      end
      @(negedge clk);
    end
    if (done_cyc < 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s_timeout: got no MduDone required one within 200 cycles", name);
    end else begin
      chk({name, "_done_stall"},  64'(bus.MduStall), 64'(0));
      chk({name, "_no_reaccept"}, 64'(bus.MduLoad),  64'(0));
    end
    @(posedge clk); #1;
    bus.MduReqE = 1'b0;
  endtask

  initial begin
    int d0;
    int d1;
    int exp_cnt[5];
    int exp_stall[5];
    int exp_step[5];
    exp_t e;

    exp_cnt   = '{0, 3, 2, 1, 0};
    exp_stall = '{1, 1, 1, 1, 0};
    exp_step  = '{0, 1, 1, 1, 0};

    cyc = 0; n_tests = 0; n_fail = 0; load_cyc = 0; step_seen = 0;
    reset = 1'b1;
    bus.MduReqE = 1'b0; bus.MduOpE = 3'b000; bus.MduWordE = 1'b0;
    bus.SrcAE = 64'h0; bus.SrcBE = 64'h0; bus.KillE = 1'b0;

    // Reset with a pending request must not stall or load.
    repeat (2) @(posedge clk);
    #1 bus.MduReqE = 1'b1;
    @(negedge clk);
    chk("rst_stall_masked", 64'(bus.MduStall), 64'(0));
    chk("rst_load_masked",  64'(bus.MduLoad),  64'(0));
    @(posedge clk); #1;
    bus.MduReqE = 1'b0;
    reset = 1'b0;
    @(negedge clk);
    chk("rst_busy",    64'(bus.MduBusy),    64'(0));
    chk("rst_cnt",     64'(bus.StepCnt),    64'(0));
    chk("rst_special", 64'(bus.MduSpecial), 64'(0));
    chk("rst_stall",   64'(bus.MduStall),   64'(0));

    // MUL: cycle-by-cycle stall, step and StepCnt profile.
    @(posedge clk); #1;
    drive(3'b000, 1'b0, 64'd6, 64'd7);
    e.lat = 4; e.sp = 2'b00; e.steps = 3;
    q.push_back(e);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("mul_cnt",   64'(bus.StepCnt),  64'(exp_cnt[k]));
      chk("mul_stall", 64'(bus.MduStall), 64'(exp_stall[k]));
      chk("mul_step",  64'(bus.MduStep),  64'(exp_step[k]));
    end
    @(posedge clk); #1;
    bus.MduReqE = 1'b0;
    @(posedge clk); #1;

    // Normal divides, then the early-out special cases.
    run_op("div",   3'b100, 1'b0, 64'd100, 64'd7, 65, 2'b00, 64, d0);
    run_op("divw",  3'b100, 1'b1, 64'd100, 64'd7, 33, 2'b00, 32, d0);
    run_op("divu0", 3'b101, 1'b0, 64'd55,  64'd0,  1, 2'b01,  0, d0);
    run_op("remw0", 3'b110, 1'b1, 64'd55,  64'hFFFF_FFFF_0000_0000, 1, 2'b01, 0, d0);
    run_op("divovf", 3'b100, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF,
           1, 2'b10, 0, d0);
    chk("special_held", 64'(bus.MduSpecial), 64'(2));
    run_op("divuovf", 3'b101, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF,
           65, 2'b00, 64, d0);
    run_op("remwovf", 3'b110, 1'b1, 64'h1234_5678_8000_0000, 64'h0000_0000_FFFF_FFFF,
           1, 2'b10, 0, d0);
    run_op("div64lo", 3'b100, 1'b0, 64'h0000_0000_8000_0000, 64'hFFFF_FFFF_FFFF_FFFF,
           65, 2'b00, 64, d0);
    run_op("mulw",  3'b001, 1'b1, 64'd3,   64'd4,  4, 2'b00,  3, d0);

    // Back-to-back MULs: second load one cycle after first done.
    run_op("b2b_a", 3'b000, 1'b0, 64'd2, 64'd3, 4, 2'b00, 3, d0);
    run_op("b2b_b", 3'b011, 1'b0, 64'd2, 64'd3, 4, 2'b00, 3, d1);
    chk("b2b_gap", 64'(load_cyc - d0), 64'(1));

    // Kill in IDLE: request ignored.
    bus.KillE = 1'b1;
    drive(3'b100, 1'b0, 64'd9, 64'd3);
    @(negedge clk);
    chk("killidle_load",  64'(bus.MduLoad),  64'(0));
    chk("killidle_stall", 64'(bus.MduStall), 64'(0));
    @(posedge clk); #1;
    bus.KillE = 1'b0; bus.MduReqE = 1'b0;
    @(negedge clk);
    chk("killidle_busy", 64'(bus.MduBusy), 64'(0));

    // Kill at BUSY cycle 10.
    @(posedge clk); #1;
    drive(3'b100, 1'b0, 64'd100, 64'd7);
    repeat (10) @(posedge clk);
    #1 bus.KillE = 1'b1;
    @(negedge clk);
    chk("kill_stall", 64'(bus.MduStall), 64'(0));
    chk("kill_step",  64'(bus.MduStep),  64'(0));
    chk("kill_cnt_before", 64'(bus.StepCnt), 64'(55));
    @(posedge clk); #1;
    bus.KillE = 1'b0; bus.MduReqE = 1'b0;
    @(negedge clk);
    chk("kill_busy", 64'(bus.MduBusy), 64'(0));
    chk("kill_cnt",  64'(bus.StepCnt), 64'(0));

    // Reset at BUSY cycle 5.
    @(posedge clk); #1;
    drive(3'b100, 1'b0, 64'd100, 64'd7);
    repeat (5) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0; bus.MduReqE = 1'b0;
    @(negedge clk);
    chk("midrst_busy",  64'(bus.MduBusy),  64'(0));
    chk("midrst_cnt",   64'(bus.StepCnt),  64'(0));
    chk("midrst_strb",  64'({bus.MduStall, bus.MduLoad, bus.MduStep, bus.MduDone}), 64'(0));
    chk("midrst_spec",  64'(bus.MduSpecial), 64'(0));

    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("queue_drained", 64'(q.size()), 64'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
